// File: rtl/bit_serial_adder_if.sv
// Request/result bundle for bit_serial_adder.
// Optional ovf signal present only when SERIAL_ADD_OVF_EN is defined.
interface bit_serial_adder_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf;

   modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
   modport master (output start, a, b, cin, input busy, done, sum, cout);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full adder, LSB-first, WIDTH cycles per result.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module full_adder (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic s,
   output logic c
);
   assign s = x ^ y ^ z;
   assign c = (x & y) | (z & (x ^ y));
endmodule

// state | meaning
// IDLE  | waiting for start
// SHIFT | one bit pair added per clock, busy=1
// DONE  | one-cycle done pulse; start here chains straight into SHIFT
module bit_serial_adder #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   bit_serial_adder_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] areg, breg, sum_q;
   logic             carry, cout_q;
   logic [CW-1:0]    cnt;
   logic             fa_s, fa_c;
   logic             accept;
   logic             busy_c, done_c;

   full_adder u_fa (
      .x (areg[0]),
      .y (breg[0]),
      .z (carry),
      .s (fa_s),
      .c (fa_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy_c    = 1'b0;
      done_c    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy_c = 1'b1;
            if (cnt == LAST) state_nxt = DONE;
         end
         DONE: begin
            done_c = 1'b1;
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         areg   <= '0;
         breg   <= '0;
         sum_q  <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         areg  <= bus.a;
         breg  <= bus.b;
         carry <= bus.cin;
         cnt   <= '0;
         sum_q <= '0;
      end else if (state == SHIFT) begin
         sum_q <= {fa_s, sum_q[WIDTH-1:1]};
         carry <= fa_c;
         areg  <= areg >> 1;
         breg  <= breg >> 1;
         cnt   <= cnt + 1'b1;
         if (cnt == LAST) cout_q <= fa_c;
      end
   end

`ifdef SERIAL_ADD_OVF_EN
   logic ovf_q;

   // carry still holds the carry into the MSB on the final shift edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                ovf_q <= 1'b0;
      else if (state == SHIFT && cnt == LAST) ovf_q <= carry ^ fa_c;
   end

   assign bus.ovf = ovf_q;
`endif

   // busy/done decode the state register only, so no input reaches them
   assign bus.busy = busy_c;
   assign bus.done = done_c;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=4): vector table,
// hand-written corner sequences and random operands against an arithmetic model.
module tb_bit_serial_adder;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   bit_serial_adder_if #(.WIDTH(W)) bus ();
   bit_serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic [3:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // {ovf, cout, sum} from integer arithmetic on unsigned and signed views
   function automatic logic [5:0] model(input logic [3:0] x, input logic [3:0] y, input logic c);
      int u, sx, sy, t;
      logic o;
      u  = int'(x) + int'(y) + int'(c);
      sx = (x >= 4'd8) ? int'(x) - 16 : int'(x);
      sy = (y >= 4'd8) ? int'(y) - 16 : int'(y);
      t  = sx + sy + int'(c);
      o  = (t > 7) || (t < -8);
      return {o, u[4:0]};
   endfunction

   task automatic check_result(input string nm, input logic [3:0] es, input logic ec, input logic eo);
      check({nm, " sum"}, 32'(bus.sum), 32'(es));
      check({nm, " cout"}, 32'(bus.cout), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
      check({nm, " ovf"}, 32'(bus.ovf), 32'(eo));
`else
      if (eo === 1'bx) check({nm, " ovf_x"}, 32'(eo), 32'd0);
`endif
   endtask

   task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc,
                         input logic [3:0] es, input logic ec, input logic eo, input string nm);
      int n, nb;
      logic [3:0] held;
      @(negedge clk);
      bus.start = 1'b1; bus.a = ta; bus.b = tb_v; bus.cin = tc;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.a = ~ta; bus.b = 4'($urandom_range(0, 15)); bus.cin = ~tc;
      n = 0; nb = 0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (bus.done) break;
         if (bus.busy) nb++;
      end
      check({nm, " latency"}, 32'(n), 32'(W + 1));
      check({nm, " busy_cycles"}, 32'(nb), 32'(W));
      check_result(nm, es, ec, eo);
      held = bus.sum;
      @(negedge clk);
      check({nm, " done_pulse"}, 32'(bus.done), 32'd0);
      check({nm, " sum_held"}, 32'(bus.sum), 32'(held));
   endtask

   initial begin
      int n, t1, dcount;
      logic [5:0] m;
      logic [3:0] ra, rb;
      logic rc;

      vecs[0]  = '{4'd5,  4'd3,  1'b0, 4'd8,  1'b0, 1'b1};
      vecs[1]  = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0};
      vecs[2]  = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
      vecs[3]  = '{4'd6,  4'd7,  1'b0, 4'd13, 1'b0, 1'b1};
      vecs[4]  = '{4'd9,  4'd9,  1'b0, 4'd2,  1'b1, 1'b1};
      vecs[5]  = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0};
      vecs[6]  = '{4'd0,  4'd0,  1'b1, 4'd1,  1'b0, 1'b0};
      vecs[7]  = '{4'd10, 4'd5,  1'b1, 4'd0,  1'b1, 1'b0};
      vecs[8]  = '{4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1};
      vecs[9]  = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1};
      vecs[10] = '{4'd3,  4'd2,  1'b0, 4'd5,  1'b0, 1'b0};

      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      #12;
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check_result("reset", 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i])
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf,
                $sformatf("vec%0d", i));

      // start during SHIFT must be ignored
      @(negedge clk);
      bus.start = 1'b1; bus.a = 4'd5; bus.b = 4'd3; bus.cin = 1'b0;
      @(posedge clk);
      #1 bus.start = 1'b0;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (n == 2) begin bus.start = 1'b1; bus.a = 4'd1; bus.b = 4'd1; end
         if (n == 3) bus.start = 1'b0;
         if (bus.done) break;
      end
      check("ignore latency", 32'(n), 32'(W + 1));
      check_result("ignore", 4'd8, 1'b0, 1'b1);
      @(negedge clk);
      check("ignore idle busy", 32'(bus.busy), 32'd0);

      // reset mid-SHIFT aborts with no done pulse
      @(negedge clk);
      bus.start = 1'b1; bus.a = 4'd15; bus.b = 4'd15; bus.cin = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort busy", 32'(bus.busy), 32'd0);
      check("abort done", 32'(bus.done), 32'd0);
      check_result("abort", 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      dcount = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.done) dcount++;
      end
      check("abort no_done", 32'(dcount), 32'd0);
      run_op(4'd6, 4'd3, 1'b1, 4'd10, 1'b0, 1'b1, "after_abort");

      // start held in DONE chains operations 5 cycles apart
      @(negedge clk);
      bus.start = 1'b1; bus.a = 4'd6; bus.b = 4'd7; bus.cin = 1'b0;
      @(posedge clk);
      #1 begin bus.a = 4'd9; bus.b = 4'd9; end
      n = 0; t1 = -100;
      while (n < 30) begin
         @(negedge clk);
         n++;
         if (bus.done) begin
            if (t1 < 0) begin
               t1 = n;
               check_result("chain1", 4'd13, 1'b0, 1'b1);
            end else begin
               check_result("chain2", 4'd2, 1'b1, 1'b1);
               bus.start = 1'b0;
               break;
            end
         end
      end
      check("chain spacing", 32'(n - t1), 32'd5);
      @(negedge clk);
      check("chain end done", 32'(bus.done), 32'd0);
      check("chain end busy", 32'(bus.busy), 32'd0);

      for (int i = 0; i < 40; i++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         rc = 1'($urandom_range(0, 1));
         m  = model(ra, rb, rc);
         run_op(ra, rb, rc, m[3:0], m[4], m[5], $sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
